// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the fetch and data ports.
// One transaction in flight; ready/err pulse back to the granted port.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t        state;
  logic          last_d;
  logic [CW-1:0] cnt;
  logic          grant_d;
  logic          expire;
  logic          busy_i;
  logic          busy_d;

  // D wins ties unless it had the previous grant
  assign grant_d = d_req & (~if_req | ~last_d);
  assign expire  = (cnt == CW'(TIMEOUT - 1)) & ~mem_ack;
  assign busy_i  = (state == BUSY_I);
  assign busy_d  = (state == BUSY_D);

  assign if_ready = busy_i & mem_ack;
  assign if_err   = busy_i & expire;
  assign if_rdata = busy_i ? mem_rdata : '0;
  assign d_ready  = busy_d & mem_ack;
  assign d_err    = busy_d & expire;
  assign d_rdata  = busy_d ? mem_rdata : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      last_d    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (if_req | d_req) begin
            mem_req <= 1'b1;
            if (grant_d) begin
              state     <= BUSY_D;
              last_d    <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state     <= BUSY_I;
              last_d    <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ack | expire) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-programmable
// memory responder; expected pulses are queued by the stimulus.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ready(if_ready),
    .if_err(if_err),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ready(d_ready),
    .d_err(d_err),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  int   ack_lat    = -1;
  int   busy_n     = 0;
  logic auto_ack   = 1'b0;
  logic manual_ack = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (a == 32'h10) return 32'h00a00093;
    return {16'hc0de, a[15:0]};
  endfunction

  assign mem_ack   = auto_ack | manual_ack;
  assign mem_rdata = rdata_of(mem_addr);

  // memory model: ack after ack_lat waiting BUSY cycles, never if < 0
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (mem_req) begin
        auto_ack = (busy_n == ack_lat);
        busy_n++;
      end else begin
        auto_ack = 1'b0;
        busy_n   = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] addr,
                      input logic we, input logic [31:0] rdata);
    exp_t e;
    e.kind  = kind;
    e.addr  = addr;
    e.we    = we;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // monitor: kind 0 if_ready, 1 if_err, 2 d_ready, 3 d_err
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && (if_ready | if_err | d_ready | d_err)) begin
        int   kind;
        exp_t e;
        kind = d_err ? 3 : d_ready ? 2 : if_err ? 1 : 0;
        chk("one_pulse", 32'($countones({if_ready, if_err, d_ready, d_err})), 1);
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse actual=kind%0d required=none", kind);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", kind, e.kind);
          chk("grant_addr", mem_addr, e.addr);
          chk("grant_we", {31'b0, mem_we}, {31'b0, e.we});
          if (kind == 0) begin
            chk("if_rdata", if_rdata, e.rdata);
            chk("d_rdata_idle", d_rdata, 0);
          end
          if (kind == 2 && !e.we) begin
            chk("d_rdata", d_rdata, e.rdata);
            chk("if_rdata_idle", if_rdata, 0);
          end
        end
      end
    end
  end

  task automatic wait_empty(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL wait_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  task automatic at_pos();
    @(posedge clock);
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (2) at_neg();
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pulses", {28'b0, if_ready, if_err, d_ready, d_err}, 0);
    reset = 1'b0;
    at_neg();

    // lone fetch, ack on first BUSY cycle
    ack_lat = 0;
    push(0, 32'h10, 1'b0, 32'h00a00093);
    if_addr = 32'h10;
    if_req  = 1'b1;
    at_pos();
    chk("fetch_mem_req", {31'b0, mem_req}, 1);
    chk("fetch_mem_we", {31'b0, mem_we}, 0);
    chk("fetch_mem_addr", mem_addr, 32'h10);
    chk("fetch_ready", {31'b0, if_ready}, 1);
    chk("fetch_rdata", if_rdata, 32'h00a00093);
    if_req = 1'b0;
    at_pos();
    chk("fetch_idle", {31'b0, mem_req}, 0);
    wait_empty(5);
    at_neg();

    // contention: D, IF, D, IF
    ack_lat = 1;
    push(2, 32'h20, 1'b0, 32'hc0de0020);
    push(0, 32'h30, 1'b0, 32'hc0de0030);
    push(2, 32'h20, 1'b0, 32'hc0de0020);
    push(0, 32'h30, 1'b0, 32'hc0de0030);
    d_addr  = 32'h20;
    d_we    = 1'b0;
    if_addr = 32'h30;
    d_req   = 1'b1;
    if_req  = 1'b1;
    wait_empty(40);
    d_req  = 1'b0;
    if_req = 1'b0;
    repeat (2) at_neg();

    // lone store, three BUSY cycles
    ack_lat = 2;
    push(2, 32'h4, 1'b1, 32'h0);
    d_we    = 1'b1;
    d_addr  = 32'h4;
    d_wdata = 32'd15;
    d_req   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_pos();
      chk("store_bus", {mem_req, mem_we, mem_addr[7:0], mem_wdata[7:0]},
          {1'b1, 1'b1, 8'h04, 8'd15});
      chk("store_ready", {31'b0, d_ready}, (i == 2) ? 1 : 0);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    at_pos();
    chk("store_idle", {31'b0, mem_req}, 0);
    wait_empty(5);
    at_neg();

    // timeout without ack, then a late ack in IDLE
    ack_lat = -1;
    push(3, 32'h40, 1'b0, 32'h0);
    d_addr = 32'h40;
    d_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_pos();
      chk("to_err", {31'b0, d_err}, (i == 3) ? 1 : 0);
    end
    d_req = 1'b0;
    at_pos();
    chk("to_mem_req_drop", {31'b0, mem_req}, 0);
    manual_ack = 1'b1;
    #1;
    chk("late_ack_ignored", {30'b0, if_ready, d_ready}, 0);
    at_neg();
    manual_ack = 1'b0;
    wait_empty(5);

    // ack on the final timeout cycle wins
    ack_lat = 3;
    push(2, 32'h44, 1'b0, 32'hc0de0044);
    d_addr = 32'h44;
    d_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_pos();
      chk("last_cycle_rdy_err", {30'b0, d_ready, d_err},
          (i == 3) ? 2 : 0);
    end
    d_req = 1'b0;
    wait_empty(5);
    at_neg();

    // reset while in BUSY_I
    ack_lat = -1;
    if_addr = 32'h50;
    if_req  = 1'b1;
    at_pos();
    chk("rb_mem_req", {31'b0, mem_req}, 1);
    at_pos();
    reset  = 1'b1;
    if_req = 1'b0;
    at_pos();
    chk("rb_after_reset", {31'b0, mem_req}, 0);
    reset      = 1'b0;
    manual_ack = 1'b1;
    #1;
    chk("rb_ack_ignored", {30'b0, if_ready, d_ready}, 0);
    at_neg();
    manual_ack = 1'b0;
    at_neg();

    // after reset, D wins the first tie again
    ack_lat = 0;
    push(2, 32'h58, 1'b0, 32'hc0de0058);
    push(0, 32'h5c, 1'b0, 32'hc0de005c);
    d_addr  = 32'h58;
    if_addr = 32'h5c;
    d_req   = 1'b1;
    if_req  = 1'b1;
    wait_empty(20);
    d_req  = 1'b0;
    if_req = 1'b0;
    repeat (3) at_neg();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
